dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates a single-ported data memory between two requesters:
//   port A (CPU load/store unit) and port B (debug/DMA loader).
//   Only one access is in flight at a time. A granted request takes
//   IDLE -> ACCESS -> RESP, so its ack arrives two cycles after the
//   request is sampled.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     a_*/b_* inputs        req, byte addr, size (00 B/01 H/10 W/11 illegal),
//                           we, uns (zero-extend loads), wdata
//     a_ack/b_ack           one-cycle completion pulse (RESP)
//     a_err/b_err           misaligned or illegal size, valid with ack
//     rdata                 extended load result, valid in the ack cycle
//     m_addr/m_din/m_be/m_wren  memory word address, write data,
//                           byte enables (big-endian lanes), write enable
//     m_dout                memory read data, combinational from m_addr
//
//   Configuration
//     DMEM_ARB_PRIORITY_EN  when defined, A always wins a tie (fixed
//                           priority); otherwise ties alternate round-robin.
module dmem_arbiter #(
    parameter int AW      = 12,
    parameter bit RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [1:0]    a_size,
    input  logic          a_we,
    input  logic          a_uns,
    input  logic [31:0]   a_wdata,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [1:0]    b_size,
    input  logic          b_we,
    input  logic          b_uns,
    input  logic [31:0]   b_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic          b_ack,
    output logic          b_err,
    output logic [31:0]   rdata,
    output logic [AW-3:0] m_addr,
    output logic [31:0]   m_din,
    output logic [3:0]    m_be,
    output logic          m_wren,
    input  logic [31:0]   m_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;

    // Captured request of the granted port; sel_q = 0 for A, 1 for B
    logic          sel_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic          grant_any;
    logic          grant_b;

    logic [3:0]    acc_be;
    logic          acc_err;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_PRIORITY_EN
    always_comb begin
        grant_any = a_req | b_req;
        grant_b   = b_req & ~a_req;
    end
`else
    // rr_last_q holds the last winner; resetting it to ~RR_INIT makes the
    // first tie go to RR_INIT.
    logic rr_last_q;

    always_comb begin
        grant_any = a_req | b_req;
        grant_b   = b_req & (~a_req | ~rr_last_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= ~RR_INIT;
        end else if (state_q == IDLE && grant_any) begin
            rr_last_q <= grant_b;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture on grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == IDLE && grant_any) begin
            sel_q   <= grant_b;
            addr_q  <= grant_b ? b_addr  : a_addr;
            size_q  <= grant_b ? b_size  : a_size;
            we_q    <= grant_b ? b_we    : a_we;
            uns_q   <= grant_b ? b_uns   : a_uns;
            wdata_q <= grant_b ? b_wdata : a_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Lane decode and alignment check (big-endian: offset 0 is [31:24])
    // ------------------------------------------------------------------
    always_comb begin
        acc_be  = '0;
        acc_err = 1'b0;
        case (size_q)
            2'b00: acc_be = 4'b1000 >> addr_q[1:0];
            2'b01: begin
                if (addr_q[0]) acc_err = 1'b1;
                else           acc_be  = addr_q[1] ? 4'b0011 : 4'b1100;
            end
            2'b10: begin
                if (addr_q[1:0] != 2'b00) acc_err = 1'b1;
                else                      acc_be  = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = m_dout[31:24];
            2'b01:   ld_byte = m_dout[23:16];
            2'b10:   ld_byte = m_dout[15:8];
            default: ld_byte = m_dout[7:0];
        endcase
        ld_half = addr_q[1] ? m_dout[15:0] : m_dout[31:16];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = m_dout;
        endcase
    end

    // Result and error status are latched at the end of ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            err_q   <= acc_err;
            rdata_q <= (we_q | acc_err) ? 32'h0 : ld_ext;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        m_be   = '0;
        m_wren = 1'b0;
        a_ack  = 1'b0;
        b_ack  = 1'b0;
        a_err  = 1'b0;
        b_err  = 1'b0;
        case (state_q)
            ACCESS: begin
                m_be   = acc_be;
                m_wren = we_q & ~acc_err;
            end
            RESP: begin
                a_ack = ~sel_q;
                b_ack = sel_q;
                a_err = ~sel_q & err_q;
                b_err = sel_q & err_q;
            end
            default: ;
        endcase
    end

    // Address and write data come straight from the capture registers,
    // so they hold their last value outside ACCESS.
    assign m_addr = addr_q[AW-1:2];
    assign m_din  = wdata_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [1:0]    a_size = '0, b_size = '0;
    logic          a_we = 1'b0, b_we = 1'b0;
    logic          a_uns = 1'b0, b_uns = 1'b0;
    logic [31:0]   a_wdata = '0, b_wdata = '0;
    logic          a_ack, a_err, b_ack, b_err;
    logic [31:0]   rdata;
    logic [AW-3:0] m_addr;
    logic [31:0]   m_din;
    logic [3:0]    m_be;
    logic          m_wren;
    logic [31:0]   m_dout;

    logic [31:0]   mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.AW(AW), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_size(a_size), .a_we(a_we),
        .a_uns(a_uns), .a_wdata(a_wdata),
        .b_req(b_req), .b_addr(b_addr), .b_size(b_size), .b_we(b_we),
        .b_uns(b_uns), .b_wdata(b_wdata),
        .a_ack(a_ack), .a_err(a_err), .b_ack(b_ack), .b_err(b_err),
        .rdata(rdata), .m_addr(m_addr), .m_din(m_din), .m_be(m_be),
        .m_wren(m_wren), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // Single-ported memory: combinational read, byte-lane write on the edge
    assign m_dout = mem[m_addr];
    always @(posedge clk) begin
        if (m_wren) begin
            if (m_be[3]) mem[m_addr][31:24] <= m_din[31:24];
            if (m_be[2]) mem[m_addr][23:16] <= m_din[23:16];
            if (m_be[1]) mem[m_addr][15:8]  <= m_din[15:8];
            if (m_be[0]) mem[m_addr][7:0]   <= m_din[7:0];
        end
    end

    typedef struct {
        bit          port;      // 0 = A, 1 = B
        logic [11:0] addr;
        logic [1:0]  size;
        bit          we;
        bit          uns;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        int          exp_wren;  // cycles with m_wren high
        bit          exp_err;
        logic [31:0] exp_rdata;
        bit          chk_mem;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int       cyc;
        bit       got;
        logic [3:0] be_seen;
        int       wren_cyc;
        @(negedge clk);
        if (v.port == 1'b0) begin
            a_addr = v.addr; a_size = v.size; a_we = v.we; a_uns = v.uns;
            a_wdata = v.wdata; a_req = 1'b1;
        end else begin
            b_addr = v.addr; b_size = v.size; b_we = v.we; b_uns = v.uns;
            b_wdata = v.wdata; b_req = 1'b1;
        end
        cyc = 0; got = 1'b0; be_seen = '0; wren_cyc = 0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            be_seen |= m_be;
            if (m_wren) wren_cyc++;
            if (a_ack || b_ack) got = 1'b1;
        end
        chk({nm, " ack_seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, cyc, 32'd2);
        chk({nm, " ack_port"}, {30'b0, a_ack, b_ack}, v.port ? 32'd1 : 32'd2);
        chk({nm, " err"}, v.port ? 32'(b_err) : 32'(a_err), 32'(v.exp_err));
        chk({nm, " other_err"}, v.port ? 32'(a_err) : 32'(b_err), 32'd0);
        chk({nm, " rdata"}, rdata, v.exp_rdata);
        chk({nm, " m_be"}, 32'(be_seen), 32'(v.exp_be));
        chk({nm, " wren_cycles"}, wren_cyc, v.exp_wren);
        chk({nm, " m_addr"}, 32'(m_addr), 32'(v.addr[11:2]));
        a_req = 1'b0;
        b_req = 1'b0;
        if (v.chk_mem) chk({nm, " mem"}, mem[v.addr[11:2]], v.exp_mem);
    endtask

    int   exp_cyc [6] = '{2, 5, 8, 11, 14, 17};
`ifdef DMEM_ARB_PRIORITY_EN
    bit   exp_b   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    bit   exp_b   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[8] = 32'h80000000;

        // port addr size we uns wdata be wren err rdata chk_mem exp_mem
        vecs.push_back('{1'b0, 12'h010, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF, 4'b1111, 1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 12'h010, 2'b10, 1'b0, 1'b0, 32'h0,        4'b1111, 0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h013, 2'b00, 1'b1, 1'b0, 32'h0000005A, 4'b0001, 1, 1'b0, 32'h0,        1'b1, 32'hDEADBE5A});
        vecs.push_back('{1'b0, 12'h010, 2'b10, 1'b0, 1'b0, 32'h0,        4'b1111, 0, 1'b0, 32'hDEADBE5A, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h020, 2'b00, 1'b0, 1'b0, 32'h0,        4'b1000, 0, 1'b0, 32'hFFFFFF80, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h020, 2'b00, 1'b0, 1'b1, 32'h0,        4'b1000, 0, 1'b0, 32'h00000080, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h022, 2'b01, 1'b1, 1'b0, 32'h00001234, 4'b0011, 1, 1'b0, 32'h0,        1'b1, 32'h80001234});
        vecs.push_back('{1'b1, 12'h020, 2'b10, 1'b0, 1'b0, 32'h0,        4'b1111, 0, 1'b0, 32'h80001234, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h020, 2'b10, 1'b1, 1'b0, 32'h80011234, 4'b1111, 1, 1'b0, 32'h0,        1'b1, 32'h80011234});
        vecs.push_back('{1'b0, 12'h020, 2'b01, 1'b0, 1'b0, 32'h0,        4'b1100, 0, 1'b0, 32'hFFFF8001, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h020, 2'b01, 1'b0, 1'b1, 32'h0,        4'b1100, 0, 1'b0, 32'h00008001, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h022, 2'b01, 1'b0, 1'b0, 32'h0,        4'b0011, 0, 1'b0, 32'h00001234, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h021, 2'b00, 1'b0, 1'b0, 32'h0,        4'b0100, 0, 1'b0, 32'h00000001, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h023, 2'b00, 1'b0, 1'b0, 32'h0,        4'b0001, 0, 1'b0, 32'h00000034, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h012, 2'b00, 1'b0, 1'b0, 32'h0,        4'b0010, 0, 1'b0, 32'hFFFFFFBE, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 12'h001, 2'b01, 1'b1, 1'b0, 32'h0000BEEF, 4'b0000, 0, 1'b1, 32'h0,        1'b1, 32'h11223344});
        vecs.push_back('{1'b0, 12'h002, 2'b10, 1'b0, 1'b0, 32'h0,        4'b0000, 0, 1'b1, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{1'b1, 12'h004, 2'b11, 1'b1, 1'b0, 32'hCAFEF00D, 4'b0000, 0, 1'b1, 32'h0,        1'b1, 32'h0});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst a_ack", 32'(a_ack), 32'd0);
        chk("rst b_ack", 32'(b_ack), 32'd0);
        chk("rst errs", {30'b0, a_err, b_err}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst m_addr", 32'(m_addr), 32'd0);
        chk("rst m_din", m_din, 32'd0);
        chk("rst m_be", 32'(m_be), 32'd0);
        chk("rst m_wren", 32'(m_wren), 32'd0);
        rst = 1'b0;

        // Contention straight after reset: first tie goes to A
        begin
            int n;
            int cyc;
            @(negedge clk);
            a_addr = 12'h010; a_size = 2'b10; a_we = 1'b0; a_uns = 1'b0;
            b_addr = 12'h020; b_size = 2'b10; b_we = 1'b0; b_uns = 1'b0;
            a_req = 1'b1; b_req = 1'b1;
            n = 0; cyc = 0;
            while (n < 6 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (a_ack || b_ack) begin
                    chk($sformatf("cont%0d both_ack", n), 32'(a_ack & b_ack), 32'd0);
                    chk($sformatf("cont%0d port_b", n), 32'(b_ack), 32'(exp_b[n]));
                    chk($sformatf("cont%0d cycle", n), cyc, exp_cyc[n]);
                    n++;
                end
            end
            chk("cont ack_count", n, 32'd6);
            a_req = 1'b0; b_req = 1'b0;
        end

        // Directed vectors
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during the ACCESS cycle of a store
        begin
            int acks;
            @(negedge clk);
            a_addr = 12'h030; a_size = 2'b10; a_we = 1'b1; a_uns = 1'b0;
            a_wdata = 32'h55AA55AA; a_req = 1'b1;
            @(negedge clk);
            chk("midrst wren_before", 32'(m_wren), 32'd1);
            #1 rst = 1'b1;
            #1 chk("midrst wren_async", 32'(m_wren), 32'd0);
            a_req = 1'b0;
            acks = 0;
            repeat (2) begin
                @(negedge clk);
                if (a_ack || b_ack) acks++;
            end
            rst = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (a_ack || b_ack) acks++;
            end
            chk("midrst no_ack", acks, 32'd0);
        end
        run_vec('{1'b0, 12'h010, 2'b10, 1'b0, 1'b0, 32'h0, 4'b1111, 0, 1'b0, 32'hDEADBE5A, 1'b0, 32'h0}, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
